// File: rtl/etapa_ex_desp_pkg.sv
// Shared RV32I shift-stage definitions: funct3 codes, datapath width,
// occupancy states of the output buffer and the buffered entry layout.
package defs_rv32i;

  localparam int ANCHO      = 32;
  localparam int ANCHO_DESP = 5;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [1:0] {
    VACIO  = 2'd0,
    UNO    = 2'd1,
    LLENO2 = 2'd2
  } estado_t;

  typedef struct packed {
    logic             error_instr;
    logic [ANCHO-1:0] resultado;
  } entrada_t;

  // Left shifts reuse the right shifter by mirroring the word on both sides.
  function automatic logic [ANCHO-1:0] invertir_bits(input logic [ANCHO-1:0] x);
    logic [ANCHO-1:0] r;
    for (int i = 0; i < ANCHO; i++) begin
      r[i] = x[ANCHO-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/etapa_ex_desp_if.sv
// ID -> EX shift operands and EX -> MEM/WB result, each with valid/ready.
interface etapa_ex_desp_if;

  logic                        in_valid;
  logic                        in_ready;
  logic [2:0]                  funct3;
  logic                        funct7_5;
  logic [defs_rv32i::ANCHO-1:0] rs1;
  logic [defs_rv32i::ANCHO-1:0] rs2;
  logic [defs_rv32i::ANCHO_DESP-1:0] shamt_imm;
  logic                        usa_imm;
  logic                        out_valid;
  logic                        out_ready;
  logic [defs_rv32i::ANCHO-1:0] resultado;
  logic                        error_instr;

  // The execute stage itself.
  modport slave (
    input  in_valid, funct3, funct7_5, rs1, rs2, shamt_imm, usa_imm, out_ready,
    output in_ready, out_valid, resultado, error_instr
  );

  // The surrounding pipeline (ID producer and MEM/WB consumer).
  modport master (
    output in_valid, funct3, funct7_5, rs1, rs2, shamt_imm, usa_imm, out_ready,
    input  in_ready, out_valid, resultado, error_instr
  );

endinterface

// File: rtl/fn_desp_der.sv
// Combinational logarithmic right shifter; con_signo fills with a's MSB.
module fn_desp_der #(
  parameter int ANCHO      = 32,
  parameter int ANCHO_DESP = 5
) (
  input  logic [ANCHO-1:0]      a,
  input  logic [ANCHO_DESP-1:0] b,
  input  logic                  con_signo,
  output logic [ANCHO-1:0]      y
);

  logic relleno;
  assign relleno = con_signo & a[ANCHO-1];

  genvar gi;
  generate
    for (gi = 0; gi < ANCHO_DESP; gi++) begin : g_etapa
      localparam int D = 1 << gi;
      logic [ANCHO-1:0] ent;
      logic [ANCHO-1:0] sal;
      if (gi == 0) begin : g_primera
        assign ent = a;
      end else begin : g_resto
        assign ent = g_etapa[gi-1].sal;
      end
      // Stage gi shifts by 2**gi when the matching amount bit is set.
      assign sal = b[gi] ? {{D{relleno}}, ent[ANCHO-1:D]} : ent;
    end
  endgenerate

  assign y = g_etapa[ANCHO_DESP-1].sal;

endmodule

// File: rtl/etapa_ex_desp.sv
// EX-stage shift unit: decode, shared right shifter, and a 2-entry skid
// buffer so the ID stage keeps full throughput under MEM/WB back-pressure.
module etapa_ex_desp
  import defs_rv32i::*;
#(
  parameter int ANCHO      = 32,
  parameter int ANCHO_DESP = 5
) (
  input  logic           clk,
  input  logic           nreset,
  etapa_ex_desp_if.slave bus
);

  logic                  es_sll;
  logic                  es_srl;
  logic                  es_sra;
  logic                  ilegal;
  logic [ANCHO_DESP-1:0] b_desp;
  logic [ANCHO-1:0]      a_desp;
  logic [ANCHO-1:0]      y_desp;
  entrada_t              entrada_nueva;
  logic                  unused_rs2;

  assign es_sll = (bus.funct3 == F3_SLL)     && !bus.funct7_5;
  assign es_srl = (bus.funct3 == F3_SRL_SRA) && !bus.funct7_5;
  assign es_sra = (bus.funct3 == F3_SRL_SRA) &&  bus.funct7_5;
  assign ilegal = !(es_sll || es_srl || es_sra);

  assign b_desp     = bus.usa_imm ? bus.shamt_imm : bus.rs2[ANCHO_DESP-1:0];
  assign unused_rs2 = ^bus.rs2[ANCHO-1:ANCHO_DESP];

  assign a_desp = es_sll ? invertir_bits(bus.rs1) : bus.rs1;

  fn_desp_der #(
    .ANCHO      (ANCHO),
    .ANCHO_DESP (ANCHO_DESP)
  ) u_desp (
    .a         (a_desp),
    .b         (b_desp),
    .con_signo (es_sra),
    .y         (y_desp)
  );

  always_comb begin
    entrada_nueva.error_instr = ilegal;
    entrada_nueva.resultado   = '0;
    if (es_sll) begin
      entrada_nueva.resultado = invertir_bits(y_desp);
    end else if (!ilegal) begin
      entrada_nueva.resultado = y_desp;
    end
  end

  estado_t  state_reg, state_next;
  entrada_t head_reg,  head_next;
  entrada_t skid_reg,  skid_next;
  logic     in_ready_reg, in_ready_next;
  logic     acepta;
  logic     saca;

  assign acepta = bus.in_valid & in_ready_reg;
  assign saca   = (state_reg != VACIO) & bus.out_ready;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    skid_next  = skid_reg;
    case (state_reg)
      VACIO: begin
        if (acepta) begin
          head_next  = entrada_nueva;
          state_next = UNO;
        end
      end
      UNO: begin
        // Accept+pop in the same cycle replaces the head directly.
        if (acepta && saca) begin
          head_next = entrada_nueva;
        end else if (acepta) begin
          skid_next  = entrada_nueva;
          state_next = LLENO2;
        end else if (saca) begin
          state_next = VACIO;
        end
      end
      LLENO2: begin
        if (saca) begin
          head_next  = skid_reg;
          state_next = UNO;
        end
      end
      default: state_next = VACIO;
    endcase
    in_ready_next = (state_next != LLENO2);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg    <= VACIO;
      head_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      head_reg     <= head_next;
      skid_reg     <= skid_next;
      in_ready_reg <= in_ready_next;
    end
  end

  assign bus.in_ready    = in_ready_reg;
  assign bus.out_valid   = (state_reg != VACIO);
  assign bus.resultado   = head_reg.resultado;
  assign bus.error_instr = head_reg.error_instr;

endmodule

// File: tb/tb_etapa_ex_desp.sv
// Self-checking bench for etapa_ex_desp: directed scenarios plus a random
// stream checked against a queue-based reference of the shift semantics.
module tb_etapa_ex_desp;

  logic clk    = 1'b0;
  logic nreset = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  logic [32:0] q[$];

  etapa_ex_desp_if bus();

  etapa_ex_desp #(.ANCHO(32), .ANCHO_DESP(5)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {error, result} from the instruction semantics.
  function automatic logic [32:0] ref_op(input logic [2:0] f3, input logic f7,
                                         input logic [31:0] a, input logic [4:0] b);
    logic signed [31:0] s;
    if (f3 == 3'b001 && !f7) return {1'b0, a << b};
    if (f3 == 3'b101 && !f7) return {1'b0, a >> b};
    if (f3 == 3'b101 &&  f7) begin
      s = $signed(a) >>> b;
      return {1'b0, s};
    end
    return {1'b1, 32'h0};
  endfunction

  function automatic logic [32:0] ref_bus();
    logic [4:0] b;
    b = bus.usa_imm ? bus.shamt_imm : bus.rs2[4:0];
    return ref_op(bus.funct3, bus.funct7_5, bus.rs1, b);
  endfunction

  task automatic set_op(input logic [2:0] f3, input logic f7, input logic [31:0] a,
                        input logic [31:0] r2, input logic [4:0] sh, input logic ui);
    bus.funct3    = f3;
    bus.funct7_5  = f7;
    bus.rs1       = a;
    bus.rs2       = r2;
    bus.shamt_imm = sh;
    bus.usa_imm   = ui;
    bus.in_valid  = 1'b1;
  endtask

  task automatic rand_op();
    int r;
    logic [2:0] f3;
    logic f7;
    r = $urandom % 8;
    if (r < 3) begin
      f3 = 3'b001;
      f7 = ($urandom % 6 == 0);
    end else if (r < 6) begin
      f3 = 3'b101;
      f7 = 1'($urandom % 2);
    end else begin
      f3 = 3'($urandom);
      f7 = 1'($urandom);
    end
    set_op(f3, f7, $urandom, $urandom, 5'($urandom), 1'($urandom));
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_op(3'b000, 1'b0, 32'h0, 32'h0, 5'h0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++;
    if (bus.resultado !== 32'h0) begin n_bad++; $display("FAIL reset_resultado: got %h expected 00000000", bus.resultado); end
    n_cmp++;
    if (bus.error_instr !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b expected 0", bus.error_instr); end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_out_valid: cycle %0d got %b expected 0", i, bus.out_valid); end
    end
    $display("reset/idle done");
  endtask

  task automatic test_srl_sra_sweep();
    logic [31:0] exp_v;
    logic [31:0] base;
    bus.out_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int n = 0; n < 32; n++) begin
        set_op(3'b101, 1'(f), 32'h80000000, $urandom, 5'(n), 1'b1);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL sweep_in_ready: f7=%0d n=%0d got %b expected 1", f, n, bus.in_ready); end
        tick();
        base = 32'hFFFFFFFF;
        exp_v = (f == 0) ? (32'h80000000 >> n) : (base << (31 - n));
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.resultado !== exp_v || bus.error_instr !== 1'b0) begin
          n_bad++;
          $display("FAIL sweep_result: f7=%0d n=%0d got v=%b r=%h e=%b expected v=1 r=%h e=0",
                   f, n, bus.out_valid, bus.resultado, bus.error_instr, exp_v);
        end
        $display("sweep f7=%0d shamt=%0d resultado=%h", f, n, bus.resultado);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL sweep_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_sll_reg();
    bus.out_ready = 1'b1;
    set_op(3'b001, 1'b0, 32'h00000001, 32'hFFFFFFE4, 5'd31, 1'b0);
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.resultado !== 32'h00000010 || bus.error_instr !== 1'b0) begin
      n_bad++;
      $display("FAIL sll_reg: got v=%b r=%h e=%b expected v=1 r=00000010 e=0",
               bus.out_valid, bus.resultado, bus.error_instr);
    end
    $display("sll_reg resultado=%h", bus.resultado);
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] a;
    logic [32:0] e;
    bus.out_ready = 1'b1;
    set_op(3'b011, 1'($urandom), $urandom, $urandom, 5'd3, 1'b1);
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.resultado !== 32'h0 || bus.error_instr !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_f3: got v=%b r=%h e=%b expected v=1 r=00000000 e=1",
               bus.out_valid, bus.resultado, bus.error_instr);
    end
    $display("illegal funct3=011 error_instr=%b", bus.error_instr);
    set_op(3'b001, 1'b1, $urandom, $urandom, 5'd7, 1'b1);
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.resultado !== 32'h0 || bus.error_instr !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_sll_f7: got v=%b r=%h e=%b expected v=1 r=00000000 e=1",
               bus.out_valid, bus.resultado, bus.error_instr);
    end
    $display("illegal sll/f7=1 error_instr=%b", bus.error_instr);
    a = $urandom;
    set_op(3'b101, 1'b0, a, 32'h0, 5'd9, 1'b1);
    e = ref_op(3'b101, 1'b0, a, 5'd9);
    tick();
    n_cmp++;
    if ({bus.error_instr, bus.resultado} !== e) begin
      n_bad++;
      $display("FAIL legal_after_illegal: got e=%b r=%h expected e=%b r=%h",
               bus.error_instr, bus.resultado, e[32], e[31:0]);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_pressure();
    logic [32:0] ea, eb, ec;
    logic [31:0] a1, a2, a3;
    a1 = $urandom; a2 = $urandom; a3 = $urandom;
    ea = ref_op(3'b101, 1'b1, a1, 5'd5);
    eb = ref_op(3'b001, 1'b0, a2, 5'd12);
    ec = ref_op(3'b101, 1'b0, a3, 5'd27);
    bus.out_ready = 1'b0;
    set_op(3'b101, 1'b1, a1, 32'h0, 5'd5, 1'b1);
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || {bus.error_instr, bus.resultado} !== ea) begin
      n_bad++; $display("FAIL bp_first: got rdy=%b r=%h expected rdy=1 r=%h", bus.in_ready, bus.resultado, ea[31:0]);
    end
    set_op(3'b001, 1'b0, a2, 32'h0, 5'd12, 1'b1);
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b0 || {bus.error_instr, bus.resultado} !== ea) begin
      n_bad++; $display("FAIL bp_second: got rdy=%b r=%h expected rdy=0 r=%h", bus.in_ready, bus.resultado, ea[31:0]);
    end
    set_op(3'b101, 1'b0, a3, 32'h0, 5'd27, 1'b1);
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || {bus.error_instr, bus.resultado} !== ea) begin
      n_bad++; $display("FAIL bp_held: got rdy=%b v=%b r=%h expected rdy=0 v=1 r=%h",
                        bus.in_ready, bus.out_valid, bus.resultado, ea[31:0]);
    end
    $display("back_pressure head=%h held", bus.resultado);
    bus.out_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || {bus.error_instr, bus.resultado} !== eb) begin
      n_bad++; $display("FAIL bp_drain_b: got rdy=%b v=%b r=%h expected rdy=1 v=1 r=%h",
                        bus.in_ready, bus.out_valid, bus.resultado, eb[31:0]);
    end
    $display("back_pressure out=%h", bus.resultado);
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || {bus.error_instr, bus.resultado} !== ec) begin
      n_bad++; $display("FAIL bp_drain_c: got v=%b r=%h expected v=1 r=%h", bus.out_valid, bus.resultado, ec[31:0]);
    end
    $display("back_pressure out=%h", bus.resultado);
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b expected 0 (duplicate)", bus.out_valid); end
  endtask

  task automatic test_random();
    logic        pend;
    logic [32:0] exp_in;
    logic        acc;
    logic        pop;
    int          guard;
    pend = 1'b0;
    exp_in = '0;
    q.delete();
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        if ($urandom % 4 != 0) begin
          rand_op();
          exp_in = ref_bus();
          pend = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom % 3 != 0);
      n_cmp++;
      if (bus.in_ready !== (q.size() < 2) || bus.out_valid !== (q.size() > 0)) begin
        n_bad++;
        $display("FAIL rnd_flags: cycle %0d got rdy=%b v=%b expected rdy=%b v=%b",
                 i, bus.in_ready, bus.out_valid, q.size() < 2, q.size() > 0);
      end
      if (q.size() > 0) begin
        n_cmp++;
        if ({bus.error_instr, bus.resultado} !== q[0]) begin
          n_bad++;
          $display("FAIL rnd_data: cycle %0d got e=%b r=%h expected e=%b r=%h",
                   i, bus.error_instr, bus.resultado, q[0][32], q[0][31:0]);
        end
      end
      acc = pend && (q.size() < 2);
      pop = (q.size() > 0) && bus.out_ready;
      if (pop) $display("rnd cycle %0d out e=%b r=%h", i, bus.error_instr, bus.resultado);
      tick();
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(exp_in);
        pend = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || {bus.error_instr, bus.resultado} !== q[0]) begin
        n_bad++;
        $display("FAIL rnd_drain: got v=%b r=%h expected v=1 r=%h", bus.out_valid, bus.resultado, q[0][31:0]);
      end
      tick();
      void'(q.pop_front());
      guard++;
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_final_empty: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    set_op(3'b101, 1'b0, $urandom, 32'h0, 5'd1, 1'b1);
    tick();
    set_op(3'b001, 1'b0, $urandom, 32'h0, 5'd2, 1'b1);
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_full: got rdy=%b v=%b expected rdy=0 v=1", bus.in_ready, bus.out_valid);
    end
    nreset = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    nreset = 1'b1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.resultado !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid_after: got v=%b rdy=%b r=%h expected v=0 rdy=1 r=00000000",
                        bus.out_valid, bus.in_ready, bus.resultado);
    end
    $display("reset mid-stream out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ghost: cycle %0d got %b expected 0", i, bus.out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_srl_sra_sweep();
    test_sll_reg();
    test_illegal();
    test_back_pressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
